// File: rtl/reg_file_pkg.sv
// Shared constants for the configuration register bank: reset image,
// named register indices and the legal read-latency range.
package reg_file_pkg;

  localparam logic [31:0] DEFAULT_RST_VALS = 32'h0881_0000;

  localparam int REG_ALU_OPA   = 0;
  localparam int REG_ALU_OPB   = 1;
  localparam int REG_UART_CFG  = 2;
  localparam int REG_DIV_RATIO = 3;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic bit rd_lat_legal(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/reg_file_rd_pipe.sv
// Extra read-response stages: delays {valid, err, data} by STAGES cycles.
// Data only advances alongside a valid so the final output holds between reads.
module reg_file_rd_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  input  logic             in_err,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic             out_err,
  output logic [WIDTH-1:0] out_data
);

  if (STAGES == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = ^{CLK, RST};
    assign out_valid = in_valid;
    assign out_err   = in_err;
    assign out_data  = in_data;
  end else begin : g_stages
    logic             v_q [STAGES];
    logic             e_q [STAGES];
    logic [WIDTH-1:0] d_q [STAGES];

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        for (int i = 0; i < STAGES; i++) begin
          v_q[i] <= 1'b0;
          e_q[i] <= 1'b0;
          d_q[i] <= '0;
        end
      end else begin
        v_q[0] <= in_valid;
        e_q[0] <= in_err;
        if (in_valid) d_q[0] <= in_data;
        for (int i = 1; i < STAGES; i++) begin
          v_q[i] <= v_q[i-1];
          e_q[i] <= e_q[i-1];
          if (v_q[i-1]) d_q[i] <= d_q[i-1];
        end
      end
    end

    assign out_valid = v_q[STAGES-1];
    assign out_err   = e_q[STAGES-1];
    assign out_data  = d_q[STAGES-1];
  end

endmodule

// File: rtl/reg_file_mp.sv
// Configuration register bank: masked/protected write port, independent read
// port with 1- or 2-cycle latency, low registers exposed continuously.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int RD_LAT  = 1,
  parameter int NUM_EXP = 4,
  parameter logic [DEPTH*WIDTH-1:0] RST_VALS = (DEPTH*WIDTH)'(DEFAULT_RST_VALS),
  parameter logic [DEPTH-1:0]       RO_MASK  = '0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     WrEn,
  input  logic [ADDR_W-1:0]        WrAddr,
  input  logic [WIDTH-1:0]         WrData,
  input  logic [WIDTH-1:0]         WrMask,
  input  logic                     RdEn,
  input  logic [ADDR_W-1:0]        RdAddr,
  output logic [WIDTH-1:0]         RdData,
  output logic                     RdData_Valid,
  output logic                     RdErr,
  output logic                     WrErr,
  output logic [NUM_EXP*WIDTH-1:0] REG_OUT
);

  if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
    $error("reg_file_mp: RD_LAT must be 1 or 2");
  end
  if (NUM_EXP > DEPTH) begin : g_bad_num_exp
    $error("reg_file_mp: NUM_EXP must not exceed DEPTH");
  end

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic wr_in_range, wr_ro, wr_ok, rd_in_range;

  always_comb begin
    wr_in_range = {1'b0, WrAddr} < DEPTH_L;
    wr_ro       = wr_in_range ? RO_MASK[WrAddr] : 1'b0;
    wr_ok       = WrEn & wr_in_range & ~wr_ro;
    rd_in_range = {1'b0, RdAddr} < DEPTH_L;
  end

  // Read-only registers are simply never written, so they keep the reset image.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RST_VALS[i*WIDTH +: WIDTH];
    end else if (wr_ok) begin
      mem[WrAddr] <= (mem[WrAddr] & ~WrMask) | (WrData & WrMask);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) WrErr <= 1'b0;
    else     WrErr <= WrEn & ~wr_ok;
  end

  // Response handshake is valid-only: the consumer cannot stall, so every
  // accepted RdEn yields exactly one RdData_Valid pulse RD_LAT cycles later,
  // with RdErr qualified by that same pulse. Data is sampled before any
  // same-edge write lands (read-before-write).
  logic             s1_valid, s1_err;
  logic [WIDTH-1:0] s1_data;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= RdEn;
      s1_err   <= RdEn & ~rd_in_range;
      if (RdEn) s1_data <= rd_in_range ? mem[RdAddr] : '0;
    end
  end

  reg_file_rd_pipe #(
    .WIDTH  (WIDTH),
    .STAGES (RD_LAT - 1)
  ) u_rd_pipe (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (s1_valid),
    .in_err    (s1_err),
    .in_data   (s1_data),
    .out_valid (RdData_Valid),
    .out_err   (RdErr),
    .out_data  (RdData)
  );

  for (genvar g = 0; g < NUM_EXP; g++) begin : g_exp
    assign REG_OUT[g*WIDTH +: WIDTH] = mem[g];
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: two instances (default; DEPTH=12/RD_LAT=2/reg3 RO)
// share stimulus and are compared each cycle against an array/queue model.
module tb_reg_file_mp;

  localparam int W  = 8;
  localparam int AW = 4;

  // clock / reset
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic          wr_en, rd_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [W-1:0]  wr_data, wr_mask;

  logic [W-1:0]   rd_data  [2];
  logic           rd_valid [2];
  logic           rd_err   [2];
  logic           wr_err   [2];
  logic [4*W-1:0] reg_out  [2];

  reg_file_mp dut0 (
    .CLK(CLK), .RST(RST),
    .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data), .WrMask(wr_mask),
    .RdEn(rd_en), .RdAddr(rd_addr),
    .RdData(rd_data[0]), .RdData_Valid(rd_valid[0]), .RdErr(rd_err[0]),
    .WrErr(wr_err[0]), .REG_OUT(reg_out[0])
  );

  reg_file_mp #(.DEPTH(12), .RD_LAT(2), .RO_MASK(12'h008)) dut1 (
    .CLK(CLK), .RST(RST),
    .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data), .WrMask(wr_mask),
    .RdEn(rd_en), .RdAddr(rd_addr),
    .RdData(rd_data[1]), .RdData_Valid(rd_valid[1]), .RdErr(rd_err[1]),
    .WrErr(wr_err[1]), .REG_OUT(reg_out[1])
  );

  // reference model
  int          m_depth [2] = '{16, 12};
  int          m_lat   [2] = '{1, 2};
  logic [15:0] m_ro    [2] = '{16'h0000, 16'h0008};
  logic [W-1:0] m_mem  [2][16];
  logic [W-1:0] m_last [2];
  logic         m_wrerr[2];
  // entries: {due_edge[15:0], err, data[7:0]}
  logic [24:0] exp_q0[$];
  logic [24:0] exp_q1[$];
  int edge_n = 0;

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [W-1:0] reset_val(input int i);
    if (i == 2) return 8'h81;
    if (i == 3) return 8'h08;
    return 8'h00;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) m_mem[k][i] = reset_val(i);
      m_last[k]  = '0;
      m_wrerr[k] = 1'b0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic model_edge();
    logic [24:0] ent;
    logic        err;
    for (int k = 0; k < 2; k++) begin
      m_wrerr[k] = 1'b0;
      if (rd_en) begin
        err = int'(rd_addr) >= m_depth[k];
        ent = {16'(edge_n + m_lat[k] - 1), err, err ? 8'h00 : m_mem[k][rd_addr]};
        if (k == 0) exp_q0.push_back(ent);
        else        exp_q1.push_back(ent);
      end
      if (wr_en) begin
        if (int'(wr_addr) < m_depth[k] && !m_ro[k][wr_addr])
          m_mem[k][wr_addr] = (m_mem[k][wr_addr] & ~wr_mask) | (wr_data & wr_mask);
        else
          m_wrerr[k] = 1'b1;
      end
    end
  endtask

  // scoreboard compare
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [24:0] ent;
    logic        ev, ee;
    logic [W-1:0] ed;
    for (int k = 0; k < 2; k++) begin
      ev = 1'b0;
      ee = 1'b0;
      if (k == 0 && exp_q0.size() > 0 && exp_q0[0][24:9] == 16'(edge_n)) begin
        ent = exp_q0.pop_front();
        ev = 1'b1;
      end else if (k == 1 && exp_q1.size() > 0 && exp_q1[0][24:9] == 16'(edge_n)) begin
        ent = exp_q1.pop_front();
        ev = 1'b1;
      end
      if (ev) begin
        ee        = ent[8];
        m_last[k] = ent[7:0];
      end
      ed = m_last[k];
      check($sformatf("d%0d_valid", k), 64'(rd_valid[k]), 64'(ev));
      check($sformatf("d%0d_rderr", k), 64'(rd_err[k]),   64'(ee));
      check($sformatf("d%0d_rddata", k), 64'(rd_data[k]), 64'(ed));
      check($sformatf("d%0d_wrerr", k), 64'(wr_err[k]),   64'(m_wrerr[k]));
      check($sformatf("d%0d_regout", k), 64'(reg_out[k]),
            64'({m_mem[k][3], m_mem[k][2], m_mem[k][1], m_mem[k][0]}));
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    edge_n++;
    if (!RST) model_edge();
    else for (int k = 0; k < 2; k++) m_wrerr[k] = 1'b0;
    @(negedge CLK);
    check_all();
  endtask

  // driver
  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                       input logic [W-1:0] wm, input logic re, input logic [AW-1:0] ra);
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    wr_mask = wm;
    rd_en   = re;
    rd_addr = ra;
    cycle();
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
    rd_en = 1'b0; rd_addr = '0;
    model_reset();
    cycle();
    cycle();
    RST = 1'b0;
    check("rst_regout0", 64'(reg_out[0]), 64'h0881_0000);
    check("rst_regout1", 64'(reg_out[1]), 64'h0881_0000);

    // default read of reg2, one cycle latency on dut0
    drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd2);
    check("rd2_valid", 64'(rd_valid[0]), 64'd1);
    check("rd2_data", 64'(rd_data[0]), 64'h81);
    idle();

    // masked write
    drive(1'b1, 4'd1, 8'hFF, 8'hFF, 1'b0, 4'd0);
    drive(1'b1, 4'd1, 8'h00, 8'h0F, 1'b0, 4'd0);
    check("mask_reg1", 64'(reg_out[0][15:8]), 64'hF0);
    drive(1'b1, 4'd1, 8'h5A, 8'h00, 1'b0, 4'd0);
    check("nomask_wrerr", 64'(wr_err[0]), 64'd0);

    // read-before-write on the same address
    drive(1'b1, 4'd5, 8'h11, 8'hFF, 1'b0, 4'd0);
    drive(1'b1, 4'd5, 8'h22, 8'hFF, 1'b1, 4'd5);
    check("rbw_old", 64'(rd_data[0]), 64'h11);
    drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd5);
    check("rbw_new", 64'(rd_data[0]), 64'h22);
    idle();
    idle();

    // protected write and out-of-range read on dut1
    drive(1'b1, 4'd3, 8'hAA, 8'hFF, 1'b0, 4'd0);
    check("ro_wrerr", 64'(wr_err[1]), 64'd1);
    check("ro_hold", 64'(reg_out[1][31:24]), 64'h08);
    idle();
    drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd13);
    idle();
    check("oor_valid", 64'(rd_valid[1]), 64'd1);
    check("oor_err", 64'(rd_err[1]), 64'd1);
    check("oor_data", 64'(rd_data[1]), 64'd0);
    drive(1'b1, 4'd14, 8'h33, 8'hFF, 1'b0, 4'd0);
    check("oor_wrerr", 64'(wr_err[1]), 64'd1);

    // back-to-back reads
    drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd0);
    drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd1);
    drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd2);
    idle();
    check("b2b_last", 64'(rd_data[1]), 64'h81);
    idle();

    // reset while a two-cycle read is in flight
    drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd1);
    rd_en = 1'b0;
    RST   = 1'b1;
    model_reset();
    #1;
    check_all();
    cycle();
    RST = 1'b0;
    idle();
    check("rst_flight_valid", 64'(rd_valid[1]), 64'd0);
    check("rst_flight_data", 64'(rd_data[1]), 64'd0);
    check("rst_image0", 64'(reg_out[0]), 64'h0881_0000);
    idle();
    idle();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), W'($urandom),
            ($urandom_range(0, 3) == 0) ? 8'hFF : W'($urandom),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)));
    end
    idle();
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised configuration register file: the next generation of the system's control/config register bank. It has one write port with bit mask and per-register write protection, and an independent read port with configurable latency (1 or 2) and error signalling. Reset values come from a parameter vector, and the first NUM_EXP registers are exposed continuously to downstream blocks (UART, clock dividers, ALU). It sits between the system controller and the functional blocks in the reference-clock domain.

## Interface
- WIDTH, 8: register width in bits.
- DEPTH, 16: number of registers. Any value ≥2; need not be a power of two.
- ADDR_W, $clog2(DEPTH): address width.
- RD_LAT, 1: read latency in cycles. Legal values are 1 and 2.
- NUM_EXP, 4: number of low registers exposed on REG_OUT. Must be ≤DEPTH.
- RST_VALS, {(DEPTH*WIDTH-32){0}, 32'h0881_0000}: reset image. Register i is at bits [i*WIDTH +: WIDTH]. Default gives reg2=0x81, reg3=0x08, others 0.
- RO_MASK, {DEPTH{0}}: bit i=1 makes register i read-only (it holds its reset value).
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-high reset.
- WrEn  in  1  write request.
- WrAddr  in  ADDR_W  write address.
- WrData  in  WIDTH  write data.
- WrMask  in  WIDTH  bit mask; 1 means the bit is written.
- RdEn  in  1  read request.
- RdAddr  in  ADDR_W  read address.
- RdData  out  WIDTH  read data; holds its last value between reads.
- RdData_Valid  out  1  one-cycle pulse per accepted read.
- RdErr  out  1  pulses together with RdData_Valid when the read address is out of range.
- WrErr  out  1  one-cycle pulse the cycle after a rejected write.
- REG_OUT  out  NUM_EXP*WIDTH  registers 0..NUM_EXP-1, flattened, taken directly from storage flops.

## Operation
- Reset (RST=1, async): storage loads RST_VALS. RdData=0, RdData_Valid=0, RdErr=0, WrErr=0, read pipeline valids cleared. REG_OUT shows the reset image.
- Write is accepted when WrEn=1, WrAddr<DEPTH and RO_MASK[WrAddr]=0.
  - reg <= (reg & ~WrMask) | (WrData & WrMask).
  - WrMask=0 is a legal no-op write; WrErr stays 0.
- Write is rejected when WrAddr≥DEPTH or the target is read-only. Storage is unchanged and WrErr=1 for one cycle.
- Reads are accepted every cycle RdEn=1. There is no back-pressure, so back-to-back reads give back-to-back valid pulses.
  - In range: RdData = storage value sampled at the accepting edge.
  - Out of range: RdData=0, RdErr=1.
- Read and write in the same cycle are both performed, with no priority between them.
  - Same address: the read returns the old (pre-write) value (read-before-write).
- Read-only registers read normally.
- REG_OUT updates on the edge after an accepted write.

## Timing
- RD_LAT=1: RdEn sampled at edge N; RdData, RdData_Valid and RdErr are registered at edge N and visible during cycle N+1.
- RD_LAT=2: one extra register stage. Outputs are visible during cycle N+2. Data is still sampled at edge N, so a write at edge N does not affect it.
- WrErr: registered at the write edge, visible for one cycle.
- RST asserted mid-read: in-flight reads are dropped. No valid pulse appears after RST deasserts.
- RST deassertion: the first write/read is accepted at the first rising edge with RST=0.
- Throughput: one write plus one read per cycle.

## Structure
- Package reg_file_pkg holds:
  - the default reset image constant, DEFAULT_RST_VALS;
  - named register index constants: REG_ALU_OPA=0, REG_ALU_OPB=1, REG_UART_CFG=2, REG_DIV_RATIO=3;
  - the legal RD_LAT range, with an elaboration-time check that errors on an illegal value.
- Sub-module reg_file_rd_pipe: a delay line of depth RD_LAT-1 carrying {valid, err, data}, reset by RST. The top module holds the storage array, write logic, error decode and the first read stage.

## Test plan
- Reset release, defaults: REG_OUT = {0x08,0x81,0x00,0x00} (reg3..reg0). Reading addr 2 returns 0x81 with RdData_Valid one cycle after RdEn.
- Masked write: reg1=0xFF, then write WrData=0x00, WrMask=0x0F → reg1=0xF0. REG_OUT[15:8]=0xF0 on the next cycle.
- Same-cycle read/write addr 5: old 0x11, write 0x22 → RdData=0x11. The next read gives 0x22.
- RO_MASK[3]=1 with a write to addr 3: WrErr pulses once and reg3 stays 0x08. With DEPTH=12, read addr 13 → RdErr=1, RdData=0, Valid=1.
- RD_LAT=2: reads of addrs 0,1,2 on consecutive cycles give three consecutive valid pulses starting 2 cycles after the first RdEn, with data in order.
- Assert RST for 1 cycle while a RD_LAT=2 read is in flight: no RdData_Valid pulse, RdData=0, and all registers are back at their reset values.
